// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: bundles the signals of the data-memory port arbiter.
// The signals fall into three groups:
//   - the MEM-stage core port
//   - the debug/loader port
//   - the BRAM port-B pins
// The master modport is the environment side: the pipeline, the debug
// master and the BRAM. The slave modport is the arbiter itself.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    // Core (MEM stage) side
    logic              core_req;
    logic [BE_W-1:0]   core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              core_stall;

    // Debug / loader side
    logic              dbg_req;
    logic [BE_W-1:0]   dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_halt;
    logic              dbg_halted;
    logic              dbg_err;

    // BRAM port B
    logic [BE_W-1:0]   web;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] dib;
    logic [DATA_W-1:0] dob;

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
        output dob,
        input  core_rdata, core_stall,
        input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_halted, dbg_err,
        input  web, addrb, dib
    );

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
        input  dob,
        output core_rdata, core_stall,
        output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_halted, dbg_err,
        output web, addrb, dib
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares DMEM BRAM port B between the pipeline MEM stage
// and a debug/loader master.
//
// Arbitration and halting:
//   - The core has priority for the port.
//   - A pending debug request wins once it has lost MAX_WAIT cycles in a row.
//   - The debug master can freeze the core (HALTED) to own the port
//     outright, for example during bulk program loading.
//
// Optional feature, enabled by defining DMEM_ARB_PROTECT_EN:
//   - In RUN, debug writes below PROTECT_TOP (the IMEM image region) are
//     consumed but not written.
//   - Each such rejected write raises a one-cycle dbg_err pulse.
module dmem_port_arbiter #(
    parameter int               ADDR_W      = 13,
    parameter int               DATA_W      = 32,
    parameter int               MAX_WAIT    = 8,
    parameter logic [ADDR_W-1:0] PROTECT_TOP = ADDR_W'(13'h0800)
) (
    input logic                 clk,
    input logic                 rst_n,
    dmem_port_arbiter_if.slave  bus
);
    localparam int         BE_W     = DATA_W / 8;
    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t            state_q;
    logic [7:0]        waitCnt_q;
    logic [7:0]        waitCnt_d;
    logic              rvalid_q;
    logic              halted_q;
    logic              err_q;

    logic              coreOwns;
    logic              dbgOwns;
    logic              stall;
    logic              wrReject;
    logic [BE_W-1:0]   portWe;
    logic [ADDR_W-1:0] portAddr;
    logic [DATA_W-1:0] portData;

    // Decide who owns the port this cycle (nothing while reset is held).
    always_comb begin
        coreOwns = 1'b0;
        dbgOwns  = 1'b0;
        stall    = 1'b0;
        if (!rst_n) begin
            coreOwns = 1'b0;
        end else if (state_q == HALTED) begin
            stall   = 1'b1;
            dbgOwns = bus.dbg_req;
        end else if (bus.core_req && (!bus.dbg_req || (waitCnt_q < WAIT_MAX))) begin
            coreOwns = 1'b1;
        end else if (bus.dbg_req) begin
            dbgOwns = 1'b1;
            stall   = bus.core_req;
        end
    end

`ifdef DMEM_ARB_PROTECT_EN
    // Reject debug writes into the protected IMEM region while the core runs.
    always_comb begin
        wrReject = dbgOwns && (state_q == RUN) && (bus.dbg_we != '0)
                   && (bus.dbg_addr < PROTECT_TOP);
    end
`else
    logic [ADDR_W-1:0] unusedProtectTop;
    assign unusedProtectTop = PROTECT_TOP;

    // Without protection every granted debug access goes through.
    always_comb begin
        wrReject = 1'b0;
    end
`endif

    // Steer the owner's request onto port B; an idle port drives zeros.
    always_comb begin
        portWe   = '0;
        portAddr = '0;
        portData = '0;
        if (coreOwns) begin
            portWe   = bus.core_we;
            portAddr = bus.core_addr;
            portData = bus.core_wdata;
        end else if (dbgOwns) begin
            portWe   = wrReject ? '0 : bus.dbg_we;
            portAddr = bus.dbg_addr;
            portData = bus.dbg_wdata;
        end
    end

    // Count consecutive cycles a pending debug request lost, saturating.
    always_comb begin
        waitCnt_d = waitCnt_q;
        if ((state_q == HALTED) || !bus.dbg_req || dbgOwns) begin
            waitCnt_d = '0;
        end else if (waitCnt_q < WAIT_MAX) begin
            waitCnt_d = waitCnt_q + 8'd1;
        end
    end

    // RUN/HALTED state machine plus the registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            waitCnt_q <= '0;
            rvalid_q  <= 1'b0;
            halted_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            waitCnt_q <= waitCnt_d;
            rvalid_q  <= dbgOwns && (bus.dbg_we == '0);
            err_q     <= wrReject;
            case (state_q)
                RUN: begin
                    if (bus.dbg_halt && !bus.core_req) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end
                end
                HALTED: begin
                    if (!bus.dbg_halt) begin
                        state_q  <= RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.core_stall = stall;
    assign bus.dbg_gnt    = dbgOwns;
    assign bus.web        = portWe;
    assign bus.addrb      = portAddr;
    assign bus.dib        = portData;
    assign bus.core_rdata = bus.dob;
    assign bus.dbg_rdata  = bus.dob;
    assign bus.dbg_rvalid = rvalid_q;
    assign bus.dbg_halted = halted_q;
    assign bus.dbg_err    = err_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: random and directed stimulus for dmem_port_arbiter.
// A write-first BRAM model sits on port B. An abstract reference model
// predicts:
//   - port ownership
//   - the memory image
//   - read data
//   - the halt status
// Honours DMEM_ARB_PROTECT_EN when the design is built with it.
module tb_dmem_port_arbiter;
    localparam int          ADDR_W      = 13;
    localparam int          DATA_W      = 32;
    localparam int          MAX_WAIT    = 8;
    localparam logic [12:0] PROTECT_TOP = 13'h0800;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .PROTECT_TOP(PROTECT_TOP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Write-first BRAM port B model
    logic [31:0] bramMem [0:8191];

    always @(posedge clk) begin : bramPortB
        logic [31:0] w;
        w = bramMem[bus.addrb];
        for (int b = 0; b < 4; b++)
            if (bus.web[b]) w[b*8 +: 8] = bus.dib[b*8 +: 8];
        bramMem[bus.addrb] = w;
        bus.dob <= w;
    end

    // Reference model state
    logic [31:0] refMem [0:8191];
    bit          refHalted;
    int          refLosses;
    bit          expRvalid;
    logic [31:0] expDbgData;
    bit          expCoreValid;
    logic [31:0] expCoreData;
    bit          expErr;

    int passCount  = 0;
    int checkCount = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input bit cReq, input logic [3:0] cWe, input logic [12:0] cAddr,
                                 input logic [31:0] cData, input bit dReq, input logic [3:0] dWe,
                                 input logic [12:0] dAddr, input logic [31:0] dData, input bit halt);
        bus.core_req   = cReq;
        bus.core_we    = cWe;
        bus.core_addr  = cAddr;
        bus.core_wdata = cData;
        bus.dbg_req    = dReq;
        bus.dbg_we     = dWe;
        bus.dbg_addr   = dAddr;
        bus.dbg_wdata  = dData;
        bus.dbg_halt   = halt;
    endtask

    task automatic checkResetState();
        checkOutput("rst_core_stall", bus.core_stall, 0);
        checkOutput("rst_dbg_gnt",    bus.dbg_gnt,    0);
        checkOutput("rst_web",        bus.web,        0);
        checkOutput("rst_addrb",      bus.addrb,      0);
        checkOutput("rst_dib",        bus.dib,        0);
        checkOutput("rst_dbg_rvalid", bus.dbg_rvalid, 0);
        checkOutput("rst_dbg_halted", bus.dbg_halted, 0);
        checkOutput("rst_dbg_err",    bus.dbg_err,    0);
        refHalted    = 0;
        refLosses    = 0;
        expRvalid    = 0;
        expCoreValid = 0;
        expErr       = 0;
    endtask

    // One clock cycle: inputs are already applied at the falling edge.
    // The task predicts, checks, steps the model across the rising edge,
    // and returns at the next falling edge.
    task automatic runCycle(output bit expGntO, output bit obsGntO);
        bit          ownCore, ownDbg, expStall, reject;
        logic [3:0]  expWeb, dWe, cWe;
        logic [12:0] expAddr;
        logic [31:0] expDib;
        bit          cReq, dReq, halt;
        #1;
        cReq = bus.core_req;
        dReq = bus.dbg_req;
        halt = bus.dbg_halt;
        cWe  = bus.core_we;
        dWe  = bus.dbg_we;
        ownCore  = 0;
        ownDbg   = 0;
        expStall = 0;
        if (refHalted) begin
            expStall = 1;
            ownDbg   = dReq;
        end else if (cReq && !(dReq && refLosses >= MAX_WAIT)) begin
            ownCore = 1;
        end else if (dReq) begin
            ownDbg   = 1;
            expStall = cReq;
        end
        reject = 0;
`ifdef DMEM_ARB_PROTECT_EN
        reject = ownDbg && !refHalted && (dWe != 0) && (bus.dbg_addr < PROTECT_TOP);
`endif
        expWeb  = 0;
        expAddr = 0;
        expDib  = 0;
        if (ownCore) begin
            expWeb  = cWe;
            expAddr = bus.core_addr;
            expDib  = bus.core_wdata;
        end else if (ownDbg) begin
            expWeb  = reject ? 4'h0 : dWe;
            expAddr = bus.dbg_addr;
            expDib  = bus.dbg_wdata;
        end

        checkOutput("core_stall", bus.core_stall, expStall);
        checkOutput("dbg_gnt",    bus.dbg_gnt,    ownDbg);
        checkOutput("web",        bus.web,        expWeb);
        checkOutput("addrb",      bus.addrb,      expAddr);
        checkOutput("dib",        bus.dib,        expDib);
        checkOutput("dbg_rvalid", bus.dbg_rvalid, expRvalid);
        checkOutput("dbg_halted", bus.dbg_halted, refHalted);
        checkOutput("dbg_err",    bus.dbg_err,    expErr);
        if (expRvalid)    checkOutput("dbg_rdata",  bus.dbg_rdata,  expDbgData);
        if (expCoreValid) checkOutput("core_rdata", bus.core_rdata, expCoreData);
        expGntO = ownDbg;
        obsGntO = bus.dbg_gnt;

        @(posedge clk);
        for (int b = 0; b < 4; b++)
            if (expWeb[b]) refMem[expAddr][b*8 +: 8] = expDib[b*8 +: 8];
        expRvalid    = ownDbg && (dWe == 0);
        expDbgData   = refMem[expAddr];
        expCoreValid = ownCore && (cWe == 0);
        expCoreData  = refMem[expAddr];
        expErr       = reject;
        if (refHalted || !dReq || ownDbg) refLosses = 0;
        else if (refLosses < MAX_WAIT)    refLosses = refLosses + 1;
        if (!refHalted) refHalted = halt && !cReq;
        else            refHalted = halt;
        @(negedge clk);
    endtask

    function automatic logic [12:0] randAddr();
        logic [12:0] a;
        a = 13'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) a = a + 13'h0800;
        return a;
    endfunction

    initial begin : mainSeq
        bit          eg, og, dPend, haltR;
        logic [3:0]  dWeR;
        logic [12:0] dAddrR;
        logic [31:0] dDataR, v;
        int          firstGnt;

        for (int i = 0; i < 8192; i++) begin
            v = (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
            bramMem[i] = v;
            refMem[i]  = v;
        end
        bramMem[13'h0040] = 32'hDEADBEEF;
        refMem[13'h0040]  = 32'hDEADBEEF;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.dob = '0;

        @(negedge clk);
        @(negedge clk);
        #1 checkResetState();
        @(negedge clk);
        rst_n = 1'b1;

        // Core read of preloaded word
        applyStimulus(1, 4'h0, 13'h0040, 0, 0, 0, 0, 0, 0);
        runCycle(eg, og);
        checkOutput("coreRd40", bus.core_rdata, 32'hDEADBEEF);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycle(eg, og);

        // Debug write then read-back of 0x0100
        applyStimulus(0, 0, 0, 0, 1, 4'hF, 13'h0100, 32'h12345678, 0);
        runCycle(eg, og);
        checkOutput("dbgWrGnt", og, 1);
        applyStimulus(0, 0, 0, 0, 1, 4'h0, 13'h0100, 0, 0);
        runCycle(eg, og);
        checkOutput("dbgRdValid", bus.dbg_rvalid, 1);
`ifndef DMEM_ARB_PROTECT_EN
        checkOutput("dbgRd100", bus.dbg_rdata, 32'h12345678);
`endif

        // Starvation bound: core requests every cycle, debug waits
        firstGnt = -1;
        dPend    = 1;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1, 4'h0, randAddr(), 0, dPend, 4'h0, 13'h0200, 0, 0);
            runCycle(eg, og);
            if (og && firstGnt < 0) firstGnt = c;
            if (eg) dPend = 0;
        end
        checkOutput("starveGntCycle", 64'(firstGnt), 64'd8);

        // Halt request while core busy, then halted operation, then release
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1, 4'h0, randAddr(), 0, 0, 0, 0, 0, 1);
            runCycle(eg, og);
        end
        checkOutput("notHaltedWhileBusy", bus.dbg_halted, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        runCycle(eg, og);
        checkOutput("haltedAfterIdle", bus.dbg_halted, 1);
        applyStimulus(1, 4'h0, 13'h0040, 0, 1, 4'hF, 13'h0010, 32'hCAFEF00D, 1);
        runCycle(eg, og);
        checkOutput("haltedErr", bus.dbg_err, 0);
        applyStimulus(1, 4'h0, 13'h0040, 0, 1, 4'h0, 13'h0010, 0, 1);
        runCycle(eg, og);
        checkOutput("haltedWrRd", bus.dbg_rdata, 32'hCAFEF00D);
        applyStimulus(1, 4'h0, 13'h0040, 0, 0, 0, 0, 0, 0);
        runCycle(eg, og);
        applyStimulus(1, 4'h0, 13'h0040, 0, 0, 0, 0, 0, 0);
        runCycle(eg, og);
        checkOutput("releasedStall", bus.core_stall, 0);

`ifdef DMEM_ARB_PROTECT_EN
        // Protected write in RUN is consumed but rejected
        v = refMem[13'h0010];
        applyStimulus(0, 0, 0, 0, 1, 4'hF, 13'h0010, 32'h0BADF00D, 0);
        runCycle(eg, og);
        checkOutput("protErr", bus.dbg_err, 1);
        applyStimulus(0, 0, 0, 0, 1, 4'h0, 13'h0010, 0, 0);
        runCycle(eg, og);
        checkOutput("protUnchanged", bus.dbg_rdata, v);
`endif

        // Randomized traffic; a debug request holds its fields until granted
        dPend  = 0;
        haltR  = 0;
        dWeR   = 0;
        dAddrR = 0;
        dDataR = 0;
        for (int c = 0; c < 600; c++) begin
            if (!dPend) begin
                dPend  = ($urandom_range(0, 2) != 0);
                dWeR   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
                dAddrR = randAddr();
                dDataR = $urandom;
            end
            if ($urandom_range(0, 39) == 0) haltR = ~haltR;
            applyStimulus($urandom_range(0, 3) != 0,
                          ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0,
                          randAddr(), $urandom, dPend, dWeR, dAddrR, dDataR, haltR);
            runCycle(eg, og);
            if (eg) dPend = 0;
        end

        // Reset right after a granted debug read drops its rvalid
        applyStimulus(0, 0, 0, 0, 1, 4'h0, 13'h0100, 0, 0);
        runCycle(eg, og);
        rst_n = 1'b0;
        #1 checkResetState();
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        runCycle(eg, og);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
